// File: rtl/hack_cpu_ctrl_pkg.sv
// Shared constants for the Hack CPU controller: instruction field bit
// positions, the default reset PC and the jump-condition helper.
package hack_cpu_ctrl_pkg;

  localparam int IS_C    = 15;
  localparam int ABIT    = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int J_LT    = 2;
  localparam int J_EQ    = 1;
  localparam int J_GT    = 0;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  // Jump bits are {lt, eq, gt}; gt means strictly positive (neither ng nor zr).
  function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
    return (j[J_LT] & ng) | (j[J_EQ] & zr) | (j[J_GT] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_cpu_ctrl_pc.sv
// Hack program counter: 16-bit register, priority reset > load > inc > hold.
// Increment wraps FFFF -> 0000.
module hack_pc #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        inc,
  input  logic [15:0] din,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge clock) begin
    if (!reset_n)  r_q <= RESET_VAL;
    else if (load) r_q <= din;
    else if (inc)  r_q <= r_q + 16'd1;
  end

  assign q = r_q;

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU sequencing/control: decodes instructions for the external ALU and
// owns A, D and PC. Optional halt detection under HACK_HALT_DETECT_EN.
module hack_cpu_ctrl
  import hack_cpu_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [15:0] instruction,
  input  logic [15:0] inM,
  input  logic [15:0] alu_out,
  input  logic        zr,
  input  logic        ng,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        zx,
  output logic        nx,
  output logic        zy,
  output logic        ny,
  output logic        f,
  output logic        no,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [15:0] addressM,
  output logic [15:0] pc
`ifdef HACK_HALT_DETECT_EN
  ,
  output logic        halted
`endif
);

  // instr_valid is a one-way strobe with no backpressure: when high, the word
  // on instruction executes at this edge; when low, no architectural state moves.
  logic [15:0] r_a;
  logic [15:0] r_d;
  logic        w_is_c;
  logic        w_frozen;
  logic        w_exec;
  logic        w_jmp;
  logic [15:0] w_pc;

  assign w_is_c = instruction[IS_C];

`ifdef HACK_HALT_DETECT_EN
  logic r_halted;
  logic w_self_jump;

  assign w_frozen    = r_halted;
  assign w_self_jump = w_exec & w_is_c & (instruction[J_LT:J_GT] == 3'b111) & (r_a == w_pc);

  always_ff @(posedge clock) begin
    if (!reset_n)         r_halted <= 1'b0;
    else if (w_self_jump) r_halted <= 1'b1;
  end

  assign halted = r_halted;
`else
  assign w_frozen = 1'b0;
`endif

  assign w_exec = instr_valid & ~w_frozen;
  assign w_jmp  = w_exec & w_is_c & jump_taken(instruction[J_LT:J_GT], zr, ng);

  always_comb begin
    {zx, nx, zy, ny, f, no} = 6'b0;
    if (instr_valid && w_is_c)
      {zx, nx, zy, ny, f, no} = instruction[COMP_HI:COMP_LO];
  end

  assign alu_x    = r_d;
  assign alu_y    = (w_is_c && instruction[ABIT]) ? inM : r_a;
  assign outM     = alu_out;
  assign addressM = r_a;
  assign writeM   = w_exec & w_is_c & instruction[DEST_M];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_a <= 16'h0000;
      r_d <= 16'h0000;
    end else if (w_exec) begin
      if (!w_is_c)                  r_a <= instruction;
      else if (instruction[DEST_A]) r_a <= alu_out;
      if (w_is_c && instruction[DEST_D]) r_d <= alu_out;
    end
  end

  // Jump target is the pre-edge A, so a simultaneous dest-A write never redirects.
  hack_pc #(
    .RESET_VAL(RESET_PC)
  ) u_pc (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (w_jmp),
    .inc    (w_exec),
    .din    (r_a),
    .q      (w_pc)
  );

  assign pc = w_pc;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl: driver pushes hand-computed expectations,
// a monitor pops and compares each cycle. Define HACK_HALT_DETECT_EN for halt tests.
module tb_hack_cpu_ctrl;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] y;
    logic [15:0] outm;
    logic [5:0]  ctrl;
    logic        wm;
    logic        hl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   drv_done = 0;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instruction = 16'h0;
  logic [15:0] inM = 16'h0;
  logic [15:0] alu_out = 16'h0;
  logic        zr = 1'b0;
  logic        ng = 1'b0;
  logic [15:0] alu_x, alu_y, outM, addressM, pc;
  logic        zx, nx, zy, ny, f, no, writeM;
  logic        w_halted;

  always #5 clock = ~clock;

  hack_cpu_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .instr_valid(instr_valid),
    .instruction(instruction),
    .inM        (inM),
    .alu_out    (alu_out),
    .zr         (zr),
    .ng         (ng),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .zx         (zx),
    .nx         (nx),
    .zy         (zy),
    .ny         (ny),
    .f          (f),
    .no         (no),
    .outM       (outM),
    .writeM     (writeM),
    .addressM   (addressM),
    .pc         (pc)
`ifdef HACK_HALT_DETECT_EN
    ,
    .halted     (w_halted)
`endif
  );

`ifndef HACK_HALT_DETECT_EN
  assign w_halted = 1'b0;
`endif

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change at the falling edge; expectations describe the outputs for
  // this cycle, i.e. the state left by the previous rising edge.
  task automatic step(input logic rst, input logic v, input logic [15:0] ins,
                      input logic [15:0] m, input logic [15:0] aout,
                      input logic z, input logic n,
                      input logic [15:0] epc, input logic [15:0] ea,
                      input logic [15:0] ed, input logic [15:0] ey,
                      input logic [5:0] ectrl, input logic ewm, input logic ehl);
    exp_t e;
    @(negedge clock);
    reset_n = rst; instr_valid = v; instruction = ins;
    inM = m; alu_out = aout; zr = z; ng = n;
    e.pc = epc; e.a = ea; e.d = ed; e.y = ey; e.outm = aout;
    e.ctrl = ectrl; e.wm = ewm; e.hl = ehl;
    exp_q.push_back(e);
  endtask

  always begin
    exp_t e;
    @(negedge clock);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc",       pc,       e.pc);
      chk("addressM", addressM, e.a);
      chk("alu_x",    alu_x,    e.d);
      chk("alu_y",    alu_y,    e.y);
      chk("outM",     outM,     e.outm);
      chk("ctrl",     {10'b0, zx, nx, zy, ny, f, no}, {10'b0, e.ctrl});
      chk("writeM",   {15'b0, writeM},   {15'b0, e.wm});
      chk("halted",   {15'b0, w_halted}, {15'b0, e.hl});
    end
  end

  localparam logic HL = 1'b1;

  initial begin
    // Reset held over two edges; writeM still follows the instruction.
    step(0, 1, 16'hE308, 16'h0, 16'h0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b001100, 1, 0);
    // Load then copy D=A.
    step(1, 1, 16'h0005, 16'h0, 16'h0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 0, 0);
    step(1, 1, 16'hEC10, 16'h0, 16'h0005, 0, 0, 16'h0001, 16'h0005, 16'h0000, 16'h0005, 6'b110000, 0, 0);
    // Memory write M=D.
    step(1, 1, 16'h0064, 16'h0, 16'h0, 0, 0, 16'h0002, 16'h0005, 16'h0005, 16'h0005, 6'b000000, 0, 0);
    step(1, 1, 16'hE308, 16'h0, 16'h0005, 0, 0, 16'h0003, 16'h0064, 16'h0005, 16'h0064, 6'b001100, 1, 0);
    // Jumps with A=000A.
    step(1, 1, 16'h000A, 16'h0, 16'h0, 0, 0, 16'h0004, 16'h0064, 16'h0005, 16'h0064, 6'b000000, 0, 0);
    step(1, 1, 16'hEA87, 16'h0, 16'h0000, 1, 0, 16'h0005, 16'h000A, 16'h0005, 16'h000A, 6'b101010, 0, 0);
    step(1, 1, 16'hE301, 16'h0, 16'h0000, 1, 0, 16'h000A, 16'h000A, 16'h0005, 16'h000A, 6'b001100, 0, 0);
    step(1, 1, 16'hE304, 16'h0, 16'hFFFF, 0, 1, 16'h000B, 16'h000A, 16'h0005, 16'h000A, 6'b001100, 0, 0);
    // AM=M+1;JEQ jumps to the old A while A takes alu_out.
    step(1, 1, 16'h0020, 16'h0, 16'h0, 0, 0, 16'h000A, 16'h000A, 16'h0005, 16'h000A, 6'b000000, 0, 0);
    step(1, 1, 16'hFDEA, 16'h002F, 16'h0030, 1, 0, 16'h000B, 16'h0020, 16'h0005, 16'h002F, 6'b110111, 1, 0);
    // Stall for three cycles.
    for (int i = 0; i < 3; i++)
      step(1, 0, 16'hEC10, 16'h0, 16'h1234, 0, 0, 16'h0020, 16'h0030, 16'h0005, 16'h0030, 6'b000000, 0, 0);
    step(1, 1, 16'hEC10, 16'h0, 16'h0030, 0, 0, 16'h0020, 16'h0030, 16'h0005, 16'h0030, 6'b110000, 0, 0);
    // A=-1, jump to FFFF, then PC wraps to 0000.
    step(1, 1, 16'hEEA0, 16'h0, 16'hFFFF, 0, 1, 16'h0021, 16'h0030, 16'h0030, 16'h0030, 6'b111010, 0, 0);
    step(1, 1, 16'hEA87, 16'h0, 16'h0000, 1, 0, 16'h0022, 16'hFFFF, 16'h0030, 16'hFFFF, 6'b101010, 0, 0);
    step(1, 1, 16'h0003, 16'h0, 16'h0, 0, 0, 16'hFFFF, 16'hFFFF, 16'h0030, 16'hFFFF, 6'b000000, 0, 0);
    step(1, 1, 16'h0007, 16'h0, 16'h0, 0, 0, 16'h0000, 16'h0003, 16'h0030, 16'h0003, 6'b000000, 0, 0);
    // Jump to 0007, then self-jump at 0007.
    step(1, 1, 16'hEA87, 16'h0, 16'h0000, 1, 0, 16'h0001, 16'h0007, 16'h0030, 16'h0007, 6'b101010, 0, 0);
    step(1, 1, 16'hEA87, 16'h0, 16'h0000, 1, 0, 16'h0007, 16'h0007, 16'h0030, 16'h0007, 6'b101010, 0, 0);
`ifdef HACK_HALT_DETECT_EN
    step(1, 1, 16'hE308, 16'h0, 16'h0030, 0, 0, 16'h0007, 16'h0007, 16'h0030, 16'h0007, 6'b001100, 0, HL);
    step(1, 1, 16'h0005, 16'h0, 16'h0, 0, 0, 16'h0007, 16'h0007, 16'h0030, 16'h0007, 6'b000000, 0, HL);
    step(0, 1, 16'h0005, 16'h0, 16'h0, 0, 0, 16'h0007, 16'h0007, 16'h0030, 16'h0007, 6'b000000, 0, HL);
`else
    step(1, 1, 16'hEA87, 16'h0, 16'h0000, 1, 0, 16'h0007, 16'h0007, 16'h0030, 16'h0007, 6'b101010, 0, 0);
    step(1, 1, 16'hE308, 16'h0, 16'h0030, 0, 0, 16'h0007, 16'h0007, 16'h0030, 16'h0007, 6'b001100, 1, 0);
    // Reset mid-program discards the in-flight A load.
    step(0, 1, 16'h0005, 16'h0, 16'h0, 0, 0, 16'h0008, 16'h0007, 16'h0030, 16'h0007, 6'b000000, 0, 0);
`endif
    step(1, 0, 16'h0000, 16'h0, 16'h0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 0, 0);
    drv_done = 1;
  end

  initial begin
    fork
      wait (drv_done);
      #20000;
    join_any
    disable fork;
    repeat (3) @(negedge clock);
    #5;
    if (!drv_done) begin
      errors++;
      $display("FAIL timeout: driver_done %0d expected 1", drv_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: queue size %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
- Sequencing and control block for the Hack CPU; drives the control side of the existing combinational ALU.
- Decodes each 16-bit instruction and emits the six ALU control bits plus the x/y operands.
- Consumes the ALU result and its zr/ng flags, and owns the A and D registers and the program counter.
- The ALU is instantiated outside this block; this block is its controller.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- instr_valid  in  1  instruction on `instruction` is valid this cycle.
- instruction  in  16  current instruction word.
- inM  in  16  data memory read value at addressM.
- alu_out  in  16  ALU result.
- zr  in  1  ALU zero flag.
- ng  in  1  ALU negative flag.
- alu_x  out  16  ALU x operand (D register).
- alu_y  out  16  ALU y operand (A register or inM).
- zx, nx, zy, ny, f, no  out  1 each  ALU control bits.
- outM  out  16  memory write data.
- writeM  out  1  memory write strobe.
- addressM  out  16  memory address (A register).
- pc  out  16  address of the next instruction.

Behaviour:
- State: A, D and PC registers, 16 bits each.
- Reset: when reset_n is 0 at a clock edge, A=0, D=0, PC=RESET_PC. Reset overrides instr_valid.
- Instruction class: is_c = instruction[15].
- A-instruction (is_c=0): A <= instruction; D is unchanged; PC <= PC+1.
- C-instruction field decode:
  - a-bit = instruction[12]: alu_y = a ? inM : A.
  - {zx,nx,zy,ny,f,no} = instruction[11:6].
  - alu_x = D.
  - dest bits [5:3] = {A, D, M}.
  - jump bits [2:0] = {lt, eq, gt}.
- ALU control outputs are combinational. When is_c=0 or instr_valid=0, all six control bits are 0.
- Register writes on a C-instruction:
  - dest A: A <= alu_out.
  - dest D: D <= alu_out.
  - writeM = instr_valid & is_c & instruction[3] (combinational).
  - outM = alu_out; addressM = current A.
- Jump condition: jmp = (lt & ng) | (eq & zr) | (gt & ~ng & ~zr). PC <= jmp ? A_old : PC+1.
- Simultaneous dest A and jump: the jump target is the A value before this edge's write.
- Instruction latency: single cycle; results are visible the cycle after the edge.
- Stall: instr_valid=0 means no register updates and writeM=0.
- PC arithmetic: 16-bit, wraps from FFFF to 0000. No overflow flag.
- Reset mid-program: in-flight writes are discarded. writeM is not forced low during reset.

Optional Feature:
- Macro: HACK_HALT_DETECT_EN.
- When defined:
  - Adds output `halted` (1 bit), reset to 0.
  - halted is set when a valid unconditional jump (jump bits 111) targets its own address, i.e. A_old == PC.
  - Once set, halted stays 1 and freezes PC, A and D; writeM is forced to 0. Only reset clears it.
- When undefined: no `halted` port; a self-jump just repeats every cycle.

Decomposition:
- Shared package: the following constants, for reuse by the future assembler testbench.
  - Bit positions IS_C=15, ABIT=12, COMP_HI=11, COMP_LO=6, DEST_A=5, DEST_D=4, DEST_M=3, J_LT=2, J_EQ=1, J_GT=0.
  - RESET_PC default.
- One sub-module: hack_pc. A 16-bit register with reset, load, increment and hold inputs; priority is reset > load > inc > hold.

Test Plan:
1. Reset: hold reset_n=0 for 2 edges → pc=0000, addressM=0000, alu_x=0000, writeM follows instruction only.
2. Load then copy: 0x0005 (@5), then 0xEC10 (D=A).
   - During D=A: zx..no=110000, alu_y=0005.
   - Drive alu_out=0005 → D=0005, pc=0002.
3. Memory write: A=0064, then 0xE308 (M=D).
   - writeM=1, addressM=0064, outM=alu_out.
   - pc increments; A and D unchanged.
4. Jumps with A=000A:
   - 0xEA87 (0;JMP) → pc=000A.
   - 0xE301 (D;JGT) with zr=1 → pc+1.
   - 0xE304 (D;JLT) with ng=1 → pc=000A.
5. Simultaneous dest A and jump: A=0020, 0xFDEA (AM=M+1;JEQ), zr=1, alu_out=0030 → pc=0020, A=0030, writeM=1.
6. Stall: instr_valid=0 for 3 cycles with 0xEC10 applied → pc, A and D unchanged, writeM=0.
   - With HACK_HALT_DETECT_EN: at pc=0007, @7 then 0;JMP → halted=1 from next cycle, pc stuck at 0007 until reset_n=0.
